// File: rtl/row_window_reader_pkg.sv
// Shared types and default geometry for the Game-of-Life generation pipeline.
// Also used by the next-state calculator and the BRAM wrappers.
package row_window_reader_pkg;

    localparam int unsigned ROW_LENGTH = 1280;
    localparam int unsigned NUM_ROWS   = 720;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned RD_LATENCY = 1;

    typedef logic [ROW_LENGTH-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/row_window_reader_read_latency_pipe.sv
// Carries {valid, row index} alongside each BRAM read so the consumer knows
// which row rd_data holds when it arrives LATENCY cycles later.
module read_latency_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_idx,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_idx
);
    import row_window_reader_pkg::*;

    logic [LATENCY-1:0]             valid_q, valid_d;
    logic [LATENCY-1:0][ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        valid_d    = valid_q;
        idx_d      = idx_q;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/row_window_reader.sv
// Sweeps the current-state BRAM once per start and presents a zero-padded
// top/middle/bottom row window per row to the next-state calculator.
module row_window_reader #(
    parameter int unsigned ROW_LENGTH = row_window_reader_pkg::ROW_LENGTH,
    parameter int unsigned NUM_ROWS   = row_window_reader_pkg::NUM_ROWS,
    parameter int unsigned ADDR_W     = row_window_reader_pkg::ADDR_W,
    parameter int unsigned RD_LATENCY = row_window_reader_pkg::RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [ROW_LENGTH-1:0] rd_data,
    output logic [ROW_LENGTH-1:0] top_row,
    output logic [ROW_LENGTH-1:0] middle_row,
    output logic [ROW_LENGTH-1:0] bottom_row,
    output logic [ADDR_W-1:0]     calc_row,
    output logic                  calc_flg,
    output logic                  valid_set
);
    import row_window_reader_pkg::*;

    // One extra bit so the terminal compare holds when NUM_ROWS == 2**ADDR_W.
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ROW_LENGTH-1:0]   top_q, top_d;
    logic [ROW_LENGTH-1:0]   mid_q, mid_d;
    logic [ROW_LENGTH-1:0]   bot_q, bot_d;
    logic [ADDR_W-1:0]       calc_row_q, calc_row_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    logic                    pipe_valid;
    logic [ADDR_W-1:0]       pipe_idx;
    logic                    arrive;

    read_latency_pipe #(
        .LATENCY (RD_LATENCY),
        .ADDR_W  (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en_q),
        .in_idx    (rd_addr_q),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    // Data arrivals are only meaningful while a sweep is reading or draining.
    assign arrive = pipe_valid && ((state_q == READ) || (state_q == DRAIN));

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        top_d      = top_q;
        mid_d      = mid_q;
        bot_d      = bot_q;
        calc_row_d = calc_row_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = 1'b0;

        if (arrive) begin
            top_d = mid_q;
            mid_d = bot_q;
            bot_d = rd_data;
            // Row k completes the window for row k-1; row 0 only primes bottom.
            if (pipe_idx != '0) begin
                valid_d    = 1'b1;
                calc_row_d = pipe_idx - ADDR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                // done_q high means this is the done cycle; start is ignored there.
                if (start && !done_q) begin
                    state_d   = READ;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    rd_cnt_d  = CNT_W'(1);
                    busy_d    = 1'b1;
                    top_d     = '0;
                    mid_d     = '0;
                    bot_d     = '0;
                end
            end
            READ: begin
                if (rd_cnt_q == LAST_CNT) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_cnt_q[ADDR_W-1:0];
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (arrive && (pipe_idx == LAST_ROW)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Zero-pad below the last row.
                top_d      = mid_q;
                mid_d      = bot_q;
                bot_d      = '0;
                valid_d    = 1'b1;
                calc_row_d = LAST_ROW;
                state_d    = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            top_q      <= '0;
            mid_q      <= '0;
            bot_q      <= '0;
            calc_row_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            top_q      <= top_d;
            mid_q      <= mid_d;
            bot_q      <= bot_d;
            calc_row_q <= calc_row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign calc_flg   = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign top_row    = top_q;
    assign middle_row = mid_q;
    assign bottom_row = bot_q;
    assign calc_row   = calc_row_q;
    assign valid_set  = valid_q;

endmodule

// File: tb/tb_row_window_reader.sv
// Bench for row_window_reader: two instances (read latency 1 and 2) share the
// stimulus and a row memory; a cycle-level reference model predicts outputs.
module tb_row_window_reader;

    localparam int NR = 4;
    localparam int NC = 32;

    logic       clk;
    logic       rst;
    logic       start1, start2;
    logic       busy1, done1, rd_en1, calc_flg1, valid_set1;
    logic       busy2, done2, rd_en2, calc_flg2, valid_set2;
    logic [1:0] rd_addr1, calc_row1, rd_addr2, calc_row2;
    logic [7:0] rd_data1, top1, mid1, bot1;
    logic [7:0] rd_data2, top2, mid2, bot2, stage2;
    logic [7:0] mem [NR];

    int total = 0;
    int bad   = 0;

    // Observed and expected per-cycle records; ctl = {rd_en, busy, calc_flg, valid_set, done}
    logic [4:0]  o_ctl  [2][NC];
    logic [1:0]  o_addr [2][NC];
    logic [25:0] o_win  [2][NC];
    logic [4:0]  e_ctl  [NC];
    logic [1:0]  e_addr [NC];
    logic [25:0] e_win  [NC];
    logic        e_chkaddr [NC];
    logic        e_chkwin  [NC];

    row_window_reader #(.ROW_LENGTH(8), .NUM_ROWS(NR), .ADDR_W(2), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .top_row(top1), .middle_row(mid1), .bottom_row(bot1),
        .calc_row(calc_row1), .calc_flg(calc_flg1), .valid_set(valid_set1)
    );

    row_window_reader #(.ROW_LENGTH(8), .NUM_ROWS(NR), .ADDR_W(2), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .top_row(top2), .middle_row(mid2), .bottom_row(bot2),
        .calc_row(calc_row2), .calc_flg(calc_flg2), .valid_set(valid_set2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models with one and two cycles of read latency
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem[rd_addr1];
        if (rd_en2) stage2 <= mem[rd_addr2];
        rd_data2 <= stage2;
    end

    // Reset for one cycle, then run ncyc cycles with start pulses from mask and an optional reset
    task automatic capture(input int ncyc, input logic [31:0] mask, input int rst_cyc);
        @(posedge clk); #1;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            rst    = (c == rst_cyc);
            start1 = mask[c];
            start2 = mask[c];
            @(negedge clk);
            o_ctl[0][c]  = {rd_en1, busy1, calc_flg1, valid_set1, done1};
            o_ctl[1][c]  = {rd_en2, busy2, calc_flg2, valid_set2, done2};
            o_addr[0][c] = rd_addr1;
            o_addr[1][c] = rd_addr2;
            o_win[0][c]  = {top1, mid1, bot1, calc_row1};
            o_win[1][c]  = {top2, mid2, bot2, calc_row2};
        end
        @(posedge clk); #1;
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    // Reference model: timing rules relative to the accepted start cycle s
    task automatic build_expect(input int lat, input int ncyc, input logic [31:0] mask, input int rst_cyc);
        int s, d, r;
        logic rden, bsy, vld, dn, zero;
        logic [7:0] t, m, b;
        s = -1000;
        for (int c = 0; c < ncyc; c++) begin
            zero = (c == 0) || (c - 1 == rst_cyc);
            if (c - 1 == rst_cyc) s = -1000;
            d = c - s;
            rden = (d >= 1) && (d <= NR);
            bsy  = (d >= 1) && (d <= NR + 2 + lat);
            vld  = (d >= 3 + lat) && (d <= NR + 2 + lat);
            dn   = (d == NR + 3 + lat);
            e_ctl[c]     = {rden, bsy, bsy, vld, dn};
            e_chkaddr[c] = rden || zero;
            e_addr[c]    = rden ? 2'(d - 1) : 2'b00;
            e_chkwin[c]  = vld || zero;
            e_win[c]     = '0;
            if (vld) begin
                r = d - 3 - lat;
                t = 8'h00;
                b = 8'h00;
                if (r > 0) t = mem[r - 1];
                m = mem[r];
                if (r < NR - 1) b = mem[r + 1];
                e_win[c] = {t, m, b, 2'(r)};
            end
            if (mask[c] && (c != rst_cyc) && (d >= NR + 4 + lat)) s = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rd_en1, rd_addr1, busy1, done1, calc_flg1, valid_set1, calc_row1, top1, mid1, bot1} !== '0) begin
            bad++;
            $display("FAIL reset_l1 got en=%b addr=%0d busy=%b done=%b flg=%b vld=%b row=%0d win=%h/%h/%h want all zero",
                     rd_en1, rd_addr1, busy1, done1, calc_flg1, valid_set1, calc_row1, top1, mid1, bot1);
        end
        total++;
        if ({rd_en2, rd_addr2, busy2, done2, calc_flg2, valid_set2, calc_row2, top2, mid2, bot2} !== '0) begin
            bad++;
            $display("FAIL reset_l2 got en=%b addr=%0d busy=%b done=%b flg=%b vld=%b row=%0d win=%h/%h/%h want all zero",
                     rd_en2, rd_addr2, busy2, done2, calc_flg2, valid_set2, calc_row2, top2, mid2, bot2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        capture(14, 32'h1, -1);
        for (int l = 1; l <= 2; l++) begin
            build_expect(l, 14, 32'h1, -1);
            for (int c = 0; c < 14; c++) begin
                total++;
                if (o_ctl[l-1][c] !== e_ctl[c]) begin
                    bad++;
                    $display("FAIL basic_ctl lat=%0d cyc=%0d got=%b want=%b", l, c, o_ctl[l-1][c], e_ctl[c]);
                end
                if (e_chkaddr[c]) begin
                    total++;
                    if (o_addr[l-1][c] !== e_addr[c]) begin
                        bad++;
                        $display("FAIL basic_addr lat=%0d cyc=%0d got=%0d want=%0d", l, c, o_addr[l-1][c], e_addr[c]);
                    end
                end
                if (e_chkwin[c]) begin
                    total++;
                    if (o_win[l-1][c] !== e_win[c]) begin
                        bad++;
                        $display("FAIL basic_win lat=%0d cyc=%0d got=%h want=%h", l, c, o_win[l-1][c], e_win[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int nv, nd;
        logic [31:0] mask;
        mask = 32'h0000_0105;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        capture(16, mask, -1);
        for (int l = 1; l <= 2; l++) begin
            build_expect(l, 16, mask, -1);
            nv = 0; nd = 0;
            for (int c = 0; c < 16; c++) begin
                nv += int'(o_ctl[l-1][c][1]);
                nd += int'(o_ctl[l-1][c][0]);
                total++;
                if (o_ctl[l-1][c] !== e_ctl[c]) begin
                    bad++;
                    $display("FAIL ignore_ctl lat=%0d cyc=%0d got=%b want=%b", l, c, o_ctl[l-1][c], e_ctl[c]);
                end
                if (e_chkwin[c]) begin
                    total++;
                    if (o_win[l-1][c] !== e_win[c]) begin
                        bad++;
                        $display("FAIL ignore_win lat=%0d cyc=%0d got=%h want=%h", l, c, o_win[l-1][c], e_win[c]);
                    end
                end
            end
            total++;
            if (nv != 4 || nd != 1) begin
                bad++;
                $display("FAIL ignore_count lat=%0d got windows=%0d dones=%0d want 4 and 1", l, nv, nd);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mask;
        mask = 32'h0000_0081;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        capture(22, mask, 5);
        for (int l = 1; l <= 2; l++) begin
            build_expect(l, 22, mask, 5);
            for (int c = 0; c < 22; c++) begin
                total++;
                if (o_ctl[l-1][c] !== e_ctl[c]) begin
                    bad++;
                    $display("FAIL rstmid_ctl lat=%0d cyc=%0d got=%b want=%b", l, c, o_ctl[l-1][c], e_ctl[c]);
                end
                if (e_chkaddr[c]) begin
                    total++;
                    if (o_addr[l-1][c] !== e_addr[c]) begin
                        bad++;
                        $display("FAIL rstmid_addr lat=%0d cyc=%0d got=%0d want=%0d", l, c, o_addr[l-1][c], e_addr[c]);
                    end
                end
                if (e_chkwin[c]) begin
                    total++;
                    if (o_win[l-1][c] !== e_win[c]) begin
                        bad++;
                        $display("FAIL rstmid_win lat=%0d cyc=%0d got=%h want=%h", l, c, o_win[l-1][c], e_win[c]);
                    end
                end
            end
        end
    endtask

    // Start at 9 is back-to-back for latency 1 and lands on done for latency 2; 10 is the reverse
    task automatic test_back_to_back();
        logic [31:0] mask;
        mask = 32'h0000_0601;
        for (int i = 0; i < NR; i++) mem[i] = 8'($urandom_range(1, 255));
        capture(NC, mask, -1);
        for (int l = 1; l <= 2; l++) begin
            build_expect(l, NC, mask, -1);
            for (int c = 0; c < NC; c++) begin
                total++;
                if (o_ctl[l-1][c] !== e_ctl[c]) begin
                    bad++;
                    $display("FAIL b2b_ctl lat=%0d cyc=%0d got=%b want=%b", l, c, o_ctl[l-1][c], e_ctl[c]);
                end
                if (e_chkwin[c]) begin
                    total++;
                    if (o_win[l-1][c] !== e_win[c]) begin
                        bad++;
                        $display("FAIL b2b_win lat=%0d cyc=%0d got=%h want=%h", l, c, o_win[l-1][c], e_win[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mask;
        int rc;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NR; i++) mem[i] = 8'($urandom);
            mask = $urandom & $urandom & $urandom;
            mask[0] = 1'b1;
            rc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, NC - 2)) : -1;
            capture(NC, mask, rc);
            for (int l = 1; l <= 2; l++) begin
                build_expect(l, NC, mask, rc);
                for (int c = 0; c < NC; c++) begin
                    total++;
                    if (o_ctl[l-1][c] !== e_ctl[c]) begin
                        bad++;
                        $display("FAIL rand_ctl it=%0d lat=%0d cyc=%0d got=%b want=%b", it, l, c, o_ctl[l-1][c], e_ctl[c]);
                    end
                    if (e_chkaddr[c]) begin
                        total++;
                        if (o_addr[l-1][c] !== e_addr[c]) begin
                            bad++;
                            $display("FAIL rand_addr it=%0d lat=%0d cyc=%0d got=%0d want=%0d", it, l, c, o_addr[l-1][c], e_addr[c]);
                        end
                    end
                    if (e_chkwin[c]) begin
                        total++;
                        if (o_win[l-1][c] !== e_win[c]) begin
                            bad++;
                            $display("FAIL rand_win it=%0d lat=%0d cyc=%0d got=%h want=%h", it, l, c, o_win[l-1][c], e_win[c]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        stage2 = 8'h00;
        rd_data1 = 8'h00;
        rd_data2 = 8'h00;
        for (int i = 0; i < NR; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
